// File: rtl/riscv_pkg.sv
// Shared opcode constants, state encoding and opcode class helper for the
// accumulator CPU sequencer, datapath and bench.
package riscv_pkg;

  localparam logic [2:0] HALT = 3'd0;
  localparam logic [2:0] SKZ  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] AND  = 3'd3;
  localparam logic [2:0] XOR  = 3'd4;
  localparam logic [2:0] LDA  = 3'd5;
  localparam logic [2:0] STO  = 3'd6;
  localparam logic [2:0] JMP  = 3'd7;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // Opcodes whose result comes back through the ALU into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/riscv_controller.sv
// Eight-phase fetch/execute sequencer: decodes datapath strobes from the
// registered phase, holds a sticky HALTED state and counts retired instructions.
module riscv_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_aluop;
  logic             w_halt;
  logic             w_retire;

  assign w_aluop = is_aluop(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INST_ADDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An instruction retires either by completing STORE or by halting.
  assign w_retire = (r_state == STORE) || ((r_state == OP_ADDR) && (opcode == HALT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire && (r_retired != {CNT_W{1'b1}})) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    sel          = 1'b0;
    rd           = 1'b0;
    ld_ir        = 1'b0;
    inc_pc       = 1'b0;
    ld_pc        = 1'b0;
    ld_ac        = 1'b0;
    data_e       = 1'b0;
    wr           = 1'b0;
    w_halt       = 1'b0;
    case (r_state)
      INST_ADDR: begin
        sel          = 1'b1;
        w_state_next = INST_FETCH;
      end
      INST_FETCH: begin
        sel          = 1'b1;
        rd           = 1'b1;
        w_state_next = INST_LOAD;
      end
      INST_LOAD, IDLE: begin
        sel          = 1'b1;
        rd           = 1'b1;
        ld_ir        = 1'b1;
        w_state_next = (r_state == INST_LOAD) ? IDLE : OP_ADDR;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        if (opcode == HALT) begin
          w_halt       = 1'b1;
          w_state_next = HALTED;
        end else begin
          w_state_next = OP_FETCH;
        end
      end
      OP_FETCH: begin
        rd           = w_aluop;
        w_state_next = ALU_OP;
      end
      ALU_OP: begin
        rd           = w_aluop;
        inc_pc       = (opcode == SKZ) && zero;
        ld_pc        = (opcode == JMP);
        data_e       = (opcode == STO);
        w_state_next = STORE;
      end
      STORE: begin
        rd           = w_aluop;
        ld_ac        = w_aluop;
        ld_pc        = (opcode == JMP);
        data_e       = (opcode == STO);
        wr           = (opcode == STO);
        w_state_next = INST_ADDR;
      end
      HALTED: begin
        w_halt       = 1'b1;
        w_state_next = HALTED;
      end
      default: begin
        w_state_next = INST_ADDR;
      end
    endcase
  end

  // Reset masks halt immediately, before the state register catches up.
  assign halt    = w_halt & ~rst;
  assign phase   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_riscv_controller.sv
// Randomized and directed checks of riscv_controller against an instruction-level model.
module tb_riscv_controller;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = HALT;
  logic       zero = 1'b0;

  logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [3:0]  phase;
  logic [15:0] retired;
  logic        s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_data_e, s_wr, s_halt;
  logic [3:0]  s_phase;
  logic [3:0]  s_retired;

  riscv_controller u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt),
    .phase(phase), .retired(retired)
  );

  riscv_controller #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir), .inc_pc(s_inc_pc), .ld_pc(s_ld_pc),
    .ld_ac(s_ld_ac), .data_e(s_data_e), .wr(s_wr), .halt(s_halt),
    .phase(s_phase), .retired(s_retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: position within the 8-step instruction, halted flag, instructions retired.
  int m_step   = 0;
  bit m_halted = 1'b0;
  int m_cnt    = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_step   <= 0;
      m_halted <= 1'b0;
      m_cnt    <= 0;
      chk_en   <= 1'b1;
    end else if (!m_halted) begin
      if (m_step == 4 && opcode == HALT) begin
        m_halted <= 1'b1;
        m_cnt    <= m_cnt + 1;
      end else if (m_step == 7) begin
        m_step <= 0;
        m_cnt  <= m_cnt + 1;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  // Packed as {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}.
  function automatic logic [8:0] exp_outs(input int step, input bit hlt,
                                          input logic [2:0] op, input logic z, input logic r);
    logic s, rdv, li, ip, lp, la, de, w, h, alu;
    s = 0; rdv = 0; li = 0; ip = 0; lp = 0; la = 0; de = 0; w = 0; h = 0;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    if (hlt) begin
      h = 1;
    end else if (step <= 3) begin
      s   = 1;
      rdv = (step >= 1);
      li  = (step >= 2);
    end else if (step == 4) begin
      ip = 1;
      h  = (op == HALT);
    end else begin
      rdv = alu;
      la  = alu && (step == 7);
      lp  = (op == JMP) && (step >= 6);
      de  = (op == STO) && (step >= 6);
      w   = (op == STO) && (step == 7);
      ip  = (step == 6) && (op == SKZ) && z;
    end
    if (r) h = 0;
    return {s, rdv, li, ip, lp, la, de, w, h};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [8:0] e;
      e = exp_outs(m_step, m_halted, opcode, zero, rst);
      check("outs", {23'd0, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}, {23'd0, e});
      check("outs_sat", {23'd0, s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_data_e, s_wr, s_halt}, {23'd0, e});
      check("phase", {28'd0, phase}, m_halted ? 32'd8 : m_step);
      check("phase_sat", {28'd0, s_phase}, m_halted ? 32'd8 : m_step);
      check("retired", {16'd0, retired}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      check("retired_sat", {28'd0, s_retired}, (m_cnt > 15) ? 32'd15 : m_cnt);
    end
  end

  task automatic set_in(input logic r, input logic [2:0] op, input logic z);
    #1;
    rst = r; opcode = op; zero = z;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Run one instruction from INST_ADDR, recording each strobe as a per-phase bitmask.
  task automatic run_masks(input logic [2:0] op, input logic z,
                           output logic [7:0] m_rd, output logic [7:0] m_inc,
                           output logic [7:0] m_ldpc, output logic [7:0] m_ldac,
                           output logic [7:0] m_de, output logic [7:0] m_wr);
    m_rd = 0; m_inc = 0; m_ldpc = 0; m_ldac = 0; m_de = 0; m_wr = 0;
    set_in(1'b0, op, z);
    for (int i = 0; i < 8; i++) begin
      m_rd[i] = rd; m_inc[i] = inc_pc; m_ldpc[i] = ld_pc;
      m_ldac[i] = ld_ac; m_de[i] = data_e; m_wr[i] = wr;
      cyc();
    end
  endtask

  initial begin
    logic [7:0] m_rd, m_inc, m_ldpc, m_ldac, m_de, m_wr;
    cyc(); cyc();
    check("rst_phase", {28'd0, phase}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_sel", {31'd0, sel}, 32'd1);

    // HALT at PC=0
    set_in(1'b0, HALT, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("halt_seq_phase", {28'd0, phase}, i);
    end
    check("halt_at_op_addr", {31'd0, halt}, 32'd1);
    check("halt_inc_pc", {31'd0, inc_pc}, 32'd1);
    cyc();
    check("halted_retired", {16'd0, retired}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("halted_phase", {28'd0, phase}, 32'd8);
      check("halted_halt", {31'd0, halt}, 32'd1);
      check("halted_inc_pc", {31'd0, inc_pc}, 32'd0);
    end
    set_in(1'b1, HALT, 1'b0);
    #1;
    check("rst_masks_halt", {31'd0, halt}, 32'd0);
    cyc();
    check("halt_clr_phase", {28'd0, phase}, 32'd0);
    check("halt_clr_retired", {16'd0, retired}, 32'd0);

    run_masks(SKZ, 1'b1, m_rd, m_inc, m_ldpc, m_ldac, m_de, m_wr);
    check("skz_z1_inc", {24'd0, m_inc}, 32'h50);
    check("skz_retired", {16'd0, retired}, 32'd1);
    run_masks(SKZ, 1'b0, m_rd, m_inc, m_ldpc, m_ldac, m_de, m_wr);
    check("skz_z0_inc", {24'd0, m_inc}, 32'h10);

    run_masks(JMP, 1'b0, m_rd, m_inc, m_ldpc, m_ldac, m_de, m_wr);
    check("jmp_ldpc", {24'd0, m_ldpc}, 32'hC0);
    check("jmp_rd", {24'd0, m_rd}, 32'h0E);
    check("jmp_inc", {24'd0, m_inc}, 32'h10);
    check("jmp_retired", {16'd0, retired}, 32'd3);

    run_masks(STO, 1'b0, m_rd, m_inc, m_ldpc, m_ldac, m_de, m_wr);
    check("sto_de", {24'd0, m_de}, 32'hC0);
    check("sto_wr", {24'd0, m_wr}, 32'h80);
    check("sto_rd", {24'd0, m_rd}, 32'h0E);
    check("sto_ldac", {24'd0, m_ldac}, 32'h00);
    run_masks(LDA, 1'b0, m_rd, m_inc, m_ldpc, m_ldac, m_de, m_wr);
    check("lda_rd", {24'd0, m_rd}, 32'hEE);
    check("lda_ldac", {24'd0, m_ldac}, 32'h80);
    check("lda_wr", {24'd0, m_wr}, 32'h00);
    check("lda_retired", {16'd0, retired}, 32'd5);

    // Reset mid-instruction
    set_in(1'b0, STO, 1'b0);
    repeat (6) cyc();
    check("mid_phase", {28'd0, phase}, 32'd6);
    check("mid_de", {31'd0, data_e}, 32'd1);
    set_in(1'b1, STO, 1'b0);
    cyc();
    check("mid_rst_phase", {28'd0, phase}, 32'd0);
    check("mid_rst_wr", {31'd0, wr}, 32'd0);
    check("mid_rst_de", {31'd0, data_e}, 32'd0);
    check("mid_rst_halt", {31'd0, halt}, 32'd0);
    check("mid_rst_retired", {16'd0, retired}, 32'd0);

    // Saturation of the narrow counter
    set_in(1'b0, ADD, 1'b0);
    repeat (160) cyc();
    check("sat_retired4", {28'd0, s_retired}, 32'd15);
    check("sat_retired16", {16'd0, retired}, 32'd20);
    check("sat_phase", {28'd0, phase}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [2:0] op;
      logic       rr;
      op = opcode;
      if (m_step == 0 && !m_halted) begin
        op = 3'($urandom_range(1, 7));
        if ($urandom_range(0, 11) == 0) op = HALT;
      end
      rr = ($urandom_range(0, 149) == 0) || (m_halted && ($urandom_range(0, 7) == 0));
      set_in(rr, op, 1'($urandom_range(0, 1)));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
